// File: rtl/axi_cmd_master_if.sv
// Bundle of command, write/read data streams, status and AXI4 master channels
// for axi_cmd_master. The master modport is the block's own view; the slave
// modport is the view of whatever drives it (harness plus AXI memory).
interface axi_cmd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [ID_WIDTH-1:0]   cmd_id;

    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;

    logic                  sts_valid;
    logic [1:0]            sts_resp;
    logic                  sts_ready;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        output cmd_ready,
        input  wr_data, wr_strb, wr_valid,
        output wr_ready,
        output rd_data, rd_last, rd_valid,
        input  rd_ready,
        output sts_valid, sts_resp,
        input  sts_ready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        input  cmd_ready,
        output wr_data, wr_strb, wr_valid,
        input  wr_ready,
        input  rd_data, rd_last, rd_valid,
        output rd_ready,
        input  sts_valid, sts_resp,
        output sts_ready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_cmd_master.sv
// AXI4 command master: turns one command into one INCR burst, streams write
// data in and read data out combinationally, and finishes every command with
// a single status beat. One transaction in flight at a time.
module axi_cmd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input logic               clk,
    input logic               rst,
    axi_cmd_master_if.master  bus
);
    localparam int STRB_LOG2 = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, STS} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_cnt;
    logic [1:0]            r_resp;
    logic                  r_awvalid;
    logic                  r_arvalid;
    logic                  r_bready;
    logic                  r_sts_valid;

    logic [31:0] w_span;
    logic [31:0] w_end;
    logic        w_cross;
    logic        w_cmd_ready;
    logic        w_cmd_fire;
    logic        w_w_fire;
    logic        w_r_fire;
    logic [1:0]  w_r_max;
    logic        w_r_bad;
    logic        w_unused;

    // A burst whose byte span runs past the end of its 4 KB page is refused
    // before any AXI traffic; the check uses the raw command address.
    assign w_span  = (32'(bus.cmd_len) + 32'd1) << STRB_LOG2;
    assign w_end   = 32'(bus.cmd_addr[11:0]) + w_span;
    assign w_cross = w_end > 32'd4096;

    assign w_cmd_ready = (r_state == IDLE) && !rst;
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_w_fire    = (r_state == W) && bus.wr_valid && bus.m_axi_wready;
    assign w_r_fire    = (r_state == R) && bus.m_axi_rvalid && bus.rd_ready;
    assign w_r_max     = (bus.m_axi_rresp > r_resp) ? bus.m_axi_rresp : r_resp;
    assign w_r_bad     = bus.m_axi_rlast != (r_cnt == 8'd0);
    assign w_unused    = &{1'b0, bus.m_axi_bid, bus.m_axi_rid};

    assign bus.cmd_ready = w_cmd_ready;

    assign bus.m_axi_awid    = r_id;
    assign bus.m_axi_awaddr  = r_addr & ADDR_MASK;
    assign bus.m_axi_awlen   = r_len;
    assign bus.m_axi_awsize  = 3'(STRB_LOG2);
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0011;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = r_awvalid;

    assign bus.m_axi_arid    = r_id;
    assign bus.m_axi_araddr  = r_addr & ADDR_MASK;
    assign bus.m_axi_arlen   = r_len;
    assign bus.m_axi_arsize  = 3'(STRB_LOG2);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = r_arvalid;

    assign bus.m_axi_wdata  = bus.wr_data;
    assign bus.m_axi_wstrb  = bus.wr_strb;
    assign bus.m_axi_wlast  = (r_cnt == 8'd0);
    assign bus.m_axi_wvalid = (r_state == W) && bus.wr_valid;
    assign bus.wr_ready     = (r_state == W) && bus.m_axi_wready;

    assign bus.m_axi_bready = r_bready;

    assign bus.rd_data      = bus.m_axi_rdata;
    assign bus.rd_last      = (r_state == R) && bus.m_axi_rlast;
    assign bus.rd_valid     = (r_state == R) && bus.m_axi_rvalid;
    assign bus.m_axi_rready = (r_state == R) && bus.rd_ready;

    assign bus.sts_valid = r_sts_valid;
    assign bus.sts_resp  = r_resp;

    // Transaction sequencer: owns the address/len/id registers, the beat
    // counter, the sticky response and every registered handshake output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_resp      <= '0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_sts_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr <= bus.cmd_addr;
                        r_len  <= bus.cmd_len;
                        r_id   <= bus.cmd_id;
                        if (w_cross) begin
                            r_resp      <= 2'b10;
                            r_sts_valid <= 1'b1;
                            r_state     <= STS;
                        end else if (bus.cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= AR;
                        end
                    end
                end
                AW: begin
                    if (bus.m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_cnt     <= r_len;
                        r_state   <= W;
                    end
                end
                W: begin
                    if (w_w_fire) begin
                        if (r_cnt == 8'd0) begin
                            r_bready <= 1'b1;
                            r_state  <= B;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                B: begin
                    if (bus.m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_resp      <= bus.m_axi_bresp;
                        r_sts_valid <= 1'b1;
                        r_state     <= STS;
                    end
                end
                AR: begin
                    if (bus.m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_cnt     <= r_len;
                        r_resp    <= 2'b00;
                        r_state   <= R;
                    end
                end
                R: begin
                    if (w_r_fire) begin
                        r_resp <= w_r_bad ? 2'b10 : w_r_max;
                        if (bus.m_axi_rlast || (r_cnt == 8'd0)) begin
                            r_sts_valid <= 1'b1;
                            r_state     <= STS;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                STS: begin
                    if (bus.sts_ready) begin
                        r_sts_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_cmd_master.sv
// Self-checking bench for axi_cmd_master: a table of directed commands run
// against a small AXI4 memory slave, plus hand-written reset sequences.
module tb_axi_cmd_master;
    localparam int DW = 32;
    localparam int AWD = 16;
    localparam int SW = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .STRB_WIDTH(SW), .ID_WIDTH(IW)) bus ();

    axi_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [31:0] dataBase;
        logic [31:0] dataStep;
        logic        stall;
        logic [1:0]  bresp;
        logic [7:0]  rrespPat;
        int          earlyLast;
        logic        reject;
        logic [15:0] expAxAddr;
        logic [1:0]  expResp;
        int          expBeats;
        int          expLat;
    } vec_t;

    int vecCount;
    int missCount;
    int abortBeat;
    bit aborted;

    logic [31:0] mem [0:16383];

    bit          sWAct, sBPend, sRAct;
    int          sWIdx, sRIdx;
    logic [7:0]  sWLen, sRLen;
    logic [15:0] sWAddr, sRAddr;

    int          awCnt, arCnt, wCnt, rdCnt, accCyc, stsCyc, axFirst;
    bit          awSeen, arSeen, wrReadySeen, done;
    logic [1:0]  stsResp;
    logic [15:0] axAddr;
    logic [7:0]  axLen, axId;
    logic [2:0]  axSize, axProt;
    logic [1:0]  axBurst;
    logic [3:0]  axCache;
    logic        axLock;
    logic [31:0] rdBuf [0:255];
    logic        rdLastBuf [0:255];

    vec_t vecs [15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(logic w, logic [15:0] a, logic [7:0] l, logic [7:0] id,
                                   logic [31:0] base, logic [31:0] step, logic st, logic [1:0] br,
                                   logic [7:0] rp, int early, logic rej, logic [15:0] ax,
                                   logic [1:0] resp, int beats, int lat);
        vec_t v;
        v.write = w;       v.addr = a;         v.len = l;        v.id = id;
        v.dataBase = base; v.dataStep = step;  v.stall = st;     v.bresp = br;
        v.rrespPat = rp;   v.earlyLast = early; v.reject = rej;  v.expAxAddr = ax;
        v.expResp = resp;  v.expBeats = beats; v.expLat = lat;
        return v;
    endfunction

    function automatic bit roll(bit stall, int n);
        return !stall || ($urandom_range(0, n) != 0);
    endfunction

    function automatic logic [13:0] wordIdx(logic [15:0] a, int i);
        return 14'(int'(a[15:2]) + i);
    endfunction

    task automatic driveIdle();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
        bus.wr_data = '0; bus.wr_strb = '0; bus.wr_valid = 0;
        bus.rd_ready = 0; bus.sts_ready = 0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0;
        bus.m_axi_bid = '0; bus.m_axi_bresp = '0; bus.m_axi_bvalid = 0;
        bus.m_axi_arready = 0;
        bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
        bus.m_axi_rlast = 0; bus.m_axi_rvalid = 0;
    endtask

    task automatic slaveReset();
        sWAct = 0; sBPend = 0; sRAct = 0;
        sWIdx = 0; sRIdx = 0; sWLen = '0; sRLen = '0; sWAddr = '0; sRAddr = '0;
    endtask

    // Runs one command to completion (or to the abort point) against the
    // memory slave, then compares everything the vector predicts.
    task automatic applyStimulus(input vec_t v);
        int  wrIdx;
        bit  cmdDone;
        wrIdx = 0; cmdDone = 0; aborted = 0; done = 0;
        awCnt = 0; arCnt = 0; wCnt = 0; rdCnt = 0;
        accCyc = -1; stsCyc = -1; axFirst = -1;
        awSeen = 0; arSeen = 0; wrReadySeen = 0; stsResp = 2'bxx;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            bus.cmd_valid = !cmdDone;
            bus.cmd_write = v.write;
            bus.cmd_addr  = v.addr;
            bus.cmd_len   = v.len;
            bus.cmd_id    = v.id;
            bus.wr_valid  = cmdDone && v.write && (wrIdx <= int'(v.len)) && roll(v.stall, 3);
            bus.wr_data   = v.dataBase + v.dataStep * 32'(wrIdx);
            bus.wr_strb   = '1;
            bus.rd_ready  = roll(v.stall, 2);
            bus.sts_ready = roll(v.stall, 1);
            bus.m_axi_awready = !sWAct && !sBPend && roll(v.stall, 2);
            bus.m_axi_wready  = sWAct && roll(v.stall, 2);
            bus.m_axi_bvalid  = sBPend;
            bus.m_axi_bresp   = v.bresp;
            bus.m_axi_bid     = v.id;
            bus.m_axi_arready = !sRAct && roll(v.stall, 2);
            bus.m_axi_rvalid  = sRAct && roll(v.stall, 2);
            bus.m_axi_rdata   = mem[wordIdx(sRAddr, sRIdx)];
            bus.m_axi_rresp   = (sRIdx < 4) ? v.rrespPat[2*sRIdx +: 2] : 2'b00;
            bus.m_axi_rlast   = (sRIdx == int'(sRLen)) || (sRIdx == v.earlyLast);
            bus.m_axi_rid     = v.id;
            #1;
            if (abortBeat >= 0 && wCnt == abortBeat && bus.m_axi_wvalid) begin
                aborted = 1;
                return;
            end
            if (bus.wr_ready) wrReadySeen = 1;
            if (bus.m_axi_awvalid && !awSeen) begin awSeen = 1; axFirst = c; end
            if (bus.m_axi_arvalid && !arSeen) begin arSeen = 1; axFirst = c; end
            if (bus.sts_valid && stsCyc < 0) stsCyc = c;
            if (bus.cmd_valid && bus.cmd_ready) begin cmdDone = 1; accCyc = c; end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                awCnt++;
                axAddr = bus.m_axi_awaddr; axLen = bus.m_axi_awlen; axId = bus.m_axi_awid;
                axSize = bus.m_axi_awsize; axBurst = bus.m_axi_awburst; axCache = bus.m_axi_awcache;
                axLock = bus.m_axi_awlock; axProt = bus.m_axi_awprot;
                sWAct = 1; sWAddr = bus.m_axi_awaddr; sWLen = bus.m_axi_awlen; sWIdx = 0;
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                checkOutput("wlast", 32'(bus.m_axi_wlast), 32'(sWIdx == int'(sWLen)));
                mem[wordIdx(sWAddr, sWIdx)] = bus.m_axi_wdata;
                wCnt++;
                sWIdx++;
                if (sWIdx > int'(sWLen)) begin sWAct = 0; sBPend = 1; end
            end
            if (bus.wr_valid && bus.wr_ready) wrIdx++;
            if (bus.m_axi_bvalid && bus.m_axi_bready) sBPend = 0;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                arCnt++;
                axAddr = bus.m_axi_araddr; axLen = bus.m_axi_arlen; axId = bus.m_axi_arid;
                axSize = bus.m_axi_arsize; axBurst = bus.m_axi_arburst; axCache = bus.m_axi_arcache;
                axLock = bus.m_axi_arlock; axProt = bus.m_axi_arprot;
                sRAct = 1; sRAddr = bus.m_axi_araddr; sRLen = bus.m_axi_arlen; sRIdx = 0;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (rdCnt < 256) begin
                    rdBuf[rdCnt] = bus.rd_data;
                    rdLastBuf[rdCnt] = bus.rd_last;
                end
                rdCnt++;
                if (bus.m_axi_rlast) sRAct = 0;
                sRIdx++;
            end
            if (bus.sts_valid && bus.sts_ready) begin
                stsResp = bus.sts_resp;
                done = 1;
            end
            @(posedge clk);
        end
        checkOutput("completed", 32'(done), 32'd1);
        checkOutput("sts_resp", 32'(stsResp), 32'(v.expResp));
        if (v.reject) begin
            checkOutput("no_aw_ar", 32'(awSeen || arSeen), 32'd0);
            checkOutput("wr_ready_quiet", 32'(wrReadySeen), 32'd0);
            checkOutput("reject_latency", 32'(stsCyc - accCyc), 32'd1);
        end else begin
            checkOutput("addr_latency", 32'(axFirst - accCyc), 32'd1);
            checkOutput("aw_count", 32'(awCnt), v.write ? 32'd1 : 32'd0);
            checkOutput("ar_count", 32'(arCnt), v.write ? 32'd0 : 32'd1);
            checkOutput("ax_addr", 32'(axAddr), 32'(v.expAxAddr));
            checkOutput("ax_len", 32'(axLen), 32'(v.len));
            checkOutput("ax_id", 32'(axId), 32'(v.id));
            checkOutput("ax_fixed", {19'd0, axSize, axBurst, axCache, axLock, axProt},
                        {19'd0, 3'd2, 2'b01, 4'b0011, 1'b0, 3'd0});
        end
        checkOutput("w_beats", 32'(wCnt), v.write ? 32'(v.expBeats) : 32'd0);
        checkOutput("rd_beats", 32'(rdCnt), v.write ? 32'd0 : 32'(v.expBeats));
        for (int i = 0; i < rdCnt && i < 256; i++) begin
            checkOutput("rd_data", rdBuf[i], v.dataBase + v.dataStep * 32'(i));
            checkOutput("rd_last", 32'(rdLastBuf[i]), 32'(i == v.expBeats - 1));
        end
        if (v.expLat > 0) checkOutput("sts_latency", 32'(stsCyc - accCyc), 32'(v.expLat));
    endtask

    initial begin
        vecCount = 0;
        missCount = 0;
        abortBeat = -1;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        driveIdle();
        slaveReset();
        rst = 1;

        @(negedge clk);
        #1;
        checkOutput("cmd_ready_in_reset", 32'(bus.cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_handshakes",
                    32'({bus.m_axi_awvalid, bus.m_axi_arvalid, bus.m_axi_wvalid, bus.wr_ready,
                         bus.m_axi_bready, bus.rd_valid, bus.m_axi_rready, bus.sts_valid}), 32'd0);
        checkOutput("reset_fields", {bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awid}, 32'd0);
        rst = 0;
        @(negedge clk);
        #1;
        checkOutput("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        //              wr  addr      len   id     base         step       stl br     rpat   early rej ax        resp   beats lat
        vecs[0]  = mkVec(1, 16'h0100, 8'd3, 8'h05, 32'h11,      32'h11,    0, 2'b00, 8'h00, -1, 0, 16'h0100, 2'b00, 4,   0);
        vecs[1]  = mkVec(0, 16'h0100, 8'd3, 8'h06, 32'h11,      32'h11,    0, 2'b00, 8'h00, -1, 0, 16'h0100, 2'b00, 4,   0);
        vecs[2]  = mkVec(1, 16'h0200, 8'd15, 8'h07, 32'h1000,   32'h1,     1, 2'b00, 8'h00, -1, 0, 16'h0200, 2'b00, 16,  0);
        vecs[3]  = mkVec(0, 16'h0200, 8'd15, 8'h08, 32'h1000,   32'h1,     1, 2'b00, 8'h00, -1, 0, 16'h0200, 2'b00, 16,  0);
        vecs[4]  = mkVec(1, 16'h0FF8, 8'd3, 8'h09, 32'h0,       32'h0,     0, 2'b00, 8'h00, -1, 1, 16'h0000, 2'b10, 0,   1);
        vecs[5]  = mkVec(0, 16'h0FF8, 8'd3, 8'h0A, 32'h0,       32'h0,     0, 2'b00, 8'h00, -1, 1, 16'h0000, 2'b10, 0,   1);
        vecs[6]  = mkVec(1, 16'h0300, 8'd0, 8'h21, 32'hAB,      32'h0,     0, 2'b10, 8'h00, -1, 0, 16'h0300, 2'b10, 1,   4);
        vecs[7]  = mkVec(0, 16'h0100, 8'd3, 8'h22, 32'h11,      32'h11,    0, 2'b00, 8'h0C, -1, 0, 16'h0100, 2'b11, 4,   0);
        vecs[8]  = mkVec(0, 16'h0100, 8'd3, 8'h23, 32'h11,      32'h11,    0, 2'b00, 8'h00, 1,  0, 16'h0100, 2'b10, 2,   0);
        vecs[9]  = mkVec(1, 16'h0FF0, 8'd3, 8'h24, 32'h55,      32'h11,    0, 2'b00, 8'h00, -1, 0, 16'h0FF0, 2'b00, 4,   0);
        vecs[10] = mkVec(0, 16'h0FF0, 8'd3, 8'h25, 32'h55,      32'h11,    0, 2'b00, 8'h00, -1, 0, 16'h0FF0, 2'b00, 4,   0);
        vecs[11] = mkVec(1, 16'h0000, 8'd255, 8'hFF, 32'h2000,  32'h1,     1, 2'b00, 8'h00, -1, 0, 16'h0000, 2'b00, 256, 0);
        vecs[12] = mkVec(0, 16'h0000, 8'd255, 8'hFE, 32'h2000,  32'h1,     0, 2'b00, 8'h00, -1, 0, 16'h0000, 2'b00, 256, 0);
        vecs[13] = mkVec(1, 16'h0106, 8'd0, 8'h31, 32'h77,      32'h0,     0, 2'b00, 8'h00, -1, 0, 16'h0104, 2'b00, 1,   4);
        vecs[14] = mkVec(0, 16'h0104, 8'd0, 8'h32, 32'h77,      32'h0,     0, 2'b00, 8'h00, -1, 0, 16'h0104, 2'b00, 1,   3);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset in the middle of an 8-beat write");
        abortBeat = 4;
        applyStimulus(mkVec(1, 16'h0400, 8'd7, 8'h41, 32'hC0, 32'h1, 0, 2'b00, 8'h00, -1, 0,
                            16'h0400, 2'b00, 8, 0));
        checkOutput("abort_reached", 32'(aborted), 32'd1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("mid_reset_handshakes",
                    32'({bus.m_axi_awvalid, bus.m_axi_arvalid, bus.m_axi_wvalid, bus.wr_ready,
                         bus.m_axi_bready, bus.rd_valid, bus.m_axi_rready, bus.sts_valid,
                         bus.cmd_ready}), 32'd0);
        driveIdle();
        slaveReset();
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("cmd_ready_after_mid_reset", 32'(bus.cmd_ready), 32'd1);
        abortBeat = -1;
        applyStimulus(mkVec(1, 16'h0500, 8'd0, 8'h42, 32'hD5, 32'h0, 0, 2'b00, 8'h00, -1, 0,
                            16'h0500, 2'b00, 1, 4));
        applyStimulus(mkVec(0, 16'h0500, 8'd0, 8'h43, 32'hD5, 32'h0, 0, 2'b00, 8'h00, -1, 0,
                            16'h0500, 2'b00, 1, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
